sat_bin: RTL and testbench

// - Self-contained SAT solving bin: holds clause bins, var-map, var-state and level-state RAMs, loaded externally.
// - On start, runs DPLL with unit propagation and chronological backtracking over all bins; reports global SAT/UNSAT.
// - Leaf engine under the bin scheduler; RAMs are the load/readback interface.

---
 rtl/sat_bin_pkg.sv | 52 +++++
 rtl/sat_bin_bram.sv | 21 ++
 rtl/sat_bin.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_sat_bin.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_bin_pkg.sv
// Shared types and constants for the sat_bin DPLL solving bin.
// Value/literal codes, RAM word layouts, FSM states, address helper.
package sat_bin_pkg;

  localparam int NUM_CLAUSES_A_BIN = 8;
  localparam int NUM_VARS_A_BIN    = 8;
  localparam int WIDTH_BIN_ID      = 10;
  localparam int WIDTH_CLAUSES     = 2 * NUM_VARS_A_BIN;
  localparam int WIDTH_VAR         = 12;
  localparam int WIDTH_LVL         = 16;
  localparam int WIDTH_VAR_STATES  = 19;
  localparam int WIDTH_LVL_STATES  = 11;
  localparam int ADDR_W            = 9;

  localparam logic [2:0] LAST_CLS = 3'(NUM_CLAUSES_A_BIN - 1);
  localparam logic [2:0] LAST_VAR = 3'(NUM_VARS_A_BIN - 1);

  localparam logic [1:0] VAL_FREE  = 2'b00;
  localparam logic [1:0] VAL_FALSE = 2'b01;
  localparam logic [1:0] VAL_TRUE  = 2'b10;

  localparam logic [1:0] LIT_POS = 2'b01;
  localparam logic [1:0] LIT_NEG = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_PROPAGATE,
    S_BACKTRACK,
    S_FINISH
  } state_e;

  typedef struct packed {
    logic [1:0]           value;
    logic                 implied;
    logic [WIDTH_LVL-1:0] level;
  } vs_t;

  typedef struct packed {
    logic [WIDTH_BIN_ID-1:0] dcd_bin;
    logic                    has_bkt;
  } ls_t;

  // Slot addresses are 1-based: bin b, slot s lives at b*8+s+1.
  function automatic logic [ADDR_W-1:0] slot_addr(
    input logic [WIDTH_BIN_ID-1:0] b,
    input logic [2:0]              s
  );
    return ADDR_W'({b, s}) + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/sat_bin_bram.sv
// Single-port RAM, synchronous write, one-cycle registered read.
// Read-during-write returns the previous contents.
module sat_bin_bram #(
  parameter int DW = 8,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sat_bin.sv
// DPLL solving bin: unit propagation plus chronological backtracking
// over externally loaded clause, var-map, var-state and level RAMs.
module sat_bin
  import sat_bin_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  output logic                        done_o,
  output logic                        global_sat_o,
  output logic                        global_unsat_o,
  input  logic                        bin_info_en,
  input  logic [WIDTH_VAR-1:0]        nv_all_i,
  input  logic [WIDTH_CLAUSES-1:0]    nb_all_i,
  input  logic                        apply_ex_i,
  input  logic                        ram_we_c_ex_i,
  input  logic [WIDTH_CLAUSES-1:0]    ram_din_c_ex_i,
  input  logic [ADDR_W-1:0]           ram_addr_c_ex_i,
  input  logic                        ram_we_v_ex_i,
  input  logic [WIDTH_VAR-1:0]        ram_din_v_ex_i,
  input  logic [ADDR_W-1:0]           ram_addr_v_ex_i,
  input  logic                        ram_we_vs_ex_i,
  input  logic [WIDTH_VAR_STATES-1:0] ram_din_vs_ex_i,
  input  logic [ADDR_W-1:0]           ram_addr_vs_ex_i,
  input  logic                        ram_we_ls_ex_i,
  input  logic [WIDTH_LVL_STATES-1:0] ram_din_ls_ex_i,
  input  logic [ADDR_W-1:0]           ram_addr_ls_ex_i
);

  state_e state_q, state_d;
  logic [2:0] ph_q, ph_d;
  logic [WIDTH_BIN_ID-1:0] bin_q, bin_d;
  logic [2:0] slot_q, slot_d, j_q, j_d;
  logic [WIDTH_CLAUSES-1:0] cw_q, cw_d;
  logic [1:0] free_q, free_d;
  logic csat_q, csat_d, upos_q, upos_d, chg_q, chg_d;
  logic [ADDR_W-1:0] var_q, var_d, unit_q, unit_d;
  logic [WIDTH_LVL-1:0] level_q, level_d;
  logic [WIDTH_VAR-1:0] vid_q, vid_d, nv_q, nv_d;
  logic [WIDTH_CLAUSES-1:0] nb_q, nb_d;
  ls_t lsw_q, lsw_d;
  logic done_q, done_d, gsat_q, gsat_d;
  logic gunsat_q, gunsat_d;

  logic [ADDR_W-1:0] i_c_addr, i_v_addr, i_vs_addr, i_ls_addr;
  logic i_vs_we, i_ls_we;
  vs_t i_vs_din;
  ls_t i_ls_din;

  logic [ADDR_W-1:0] c_addr, v_addr, vs_addr, ls_addr;
  logic vs_we, ls_we;
  logic [WIDTH_VAR_STATES-1:0] vs_din;
  logic [WIDTH_LVL_STATES-1:0] ls_din;
  logic [WIDTH_CLAUSES-1:0] c_rd;
  logic [WIDTH_VAR-1:0] v_rd;
  vs_t vs_rd;
  ls_t ls_rd;

  logic [1:0] lit;
  logic last_bin;
  logic lit_ok;
  logic [WIDTH_LVL-1:0] lvl_inc;

  assign c_addr  = apply_ex_i ? ram_addr_c_ex_i : i_c_addr;
  assign v_addr  = apply_ex_i ? ram_addr_v_ex_i : i_v_addr;
  assign vs_addr = apply_ex_i ? ram_addr_vs_ex_i : i_vs_addr;
  assign ls_addr = apply_ex_i ? ram_addr_ls_ex_i : i_ls_addr;
  assign vs_we   = apply_ex_i ? ram_we_vs_ex_i : i_vs_we;
  assign ls_we   = apply_ex_i ? ram_we_ls_ex_i : i_ls_we;
  assign vs_din  = apply_ex_i ? ram_din_vs_ex_i : i_vs_din;
  assign ls_din  = apply_ex_i ? ram_din_ls_ex_i : i_ls_din;

  sat_bin_bram #(.DW(WIDTH_CLAUSES), .AW(ADDR_W)) u_c (
    .clk(clk), .we(apply_ex_i & ram_we_c_ex_i),
    .addr(c_addr), .din(ram_din_c_ex_i), .rdata(c_rd));
  sat_bin_bram #(.DW(WIDTH_VAR), .AW(ADDR_W)) u_v (
    .clk(clk), .we(apply_ex_i & ram_we_v_ex_i),
    .addr(v_addr), .din(ram_din_v_ex_i), .rdata(v_rd));
  sat_bin_bram #(.DW(WIDTH_VAR_STATES), .AW(ADDR_W)) u_vs (
    .clk(clk), .we(vs_we),
    .addr(vs_addr), .din(vs_din), .rdata(vs_rd));
  sat_bin_bram #(.DW(WIDTH_LVL_STATES), .AW(ADDR_W)) u_ls (
    .clk(clk), .we(ls_we),
    .addr(ls_addr), .din(ls_din), .rdata(ls_rd));

  always_comb begin
    state_d = state_q;  ph_d = ph_q;
    bin_d = bin_q;  slot_d = slot_q;  j_d = j_q;
    cw_d = cw_q;  free_d = free_q;  csat_d = csat_q;
    upos_d = upos_q;  chg_d = chg_q;
    var_d = var_q;  unit_d = unit_q;
    level_d = level_q;  vid_d = vid_q;  lsw_d = lsw_q;
    nv_d = nv_q;  nb_d = nb_q;
    done_d = done_q;  gsat_d = gsat_q;  gunsat_d = gunsat_q;
    i_c_addr = '0;  i_v_addr = '0;
    i_vs_addr = '0;  i_ls_addr = '0;
    i_vs_we = 1'b0;  i_ls_we = 1'b0;
    i_vs_din = '0;  i_ls_din = '0;
    lit = cw_q[{j_q, 1'b0} +: 2];
    lit_ok = (lit == LIT_POS) || (lit == LIT_NEG);
    last_bin = (16'(bin_q) + 16'd1) >= nb_q;
    lvl_inc = level_q + 16'd1;
    if (bin_info_en) begin
      nv_d = nv_all_i;
      nb_d = nb_all_i;
    end
    unique case (state_q)
      S_IDLE: if (start_i && !apply_ex_i) begin
        done_d = 1'b0;  gsat_d = 1'b0;  gunsat_d = 1'b0;
        level_d = '0;  bin_d = '0;  slot_d = '0;
        ph_d = '0;  chg_d = 1'b0;
        state_d = S_PROPAGATE;
      end
      S_PROPAGATE: case (ph_q)
        3'd0: begin
          i_c_addr = slot_addr(bin_q, slot_q);
          ph_d = 3'd1;
        end
        3'd1: begin
          cw_d = c_rd;  j_d = '0;  free_d = '0;  csat_d = 1'b0;
          ph_d = (c_rd == '0) ? 3'd6 : 3'd2;
        end
        3'd2: if (lit_ok) begin
          i_v_addr = slot_addr(bin_q, j_q);
          ph_d = 3'd3;
        end else begin
          j_d = j_q + 3'd1;
          ph_d = (j_q == LAST_VAR) ? 3'd5 : 3'd2;
        end
        3'd3: if (v_rd != '0) begin
          i_vs_addr = v_rd[ADDR_W-1:0];
          var_d = v_rd[ADDR_W-1:0];
          ph_d = 3'd4;
        end else begin
          j_d = j_q + 3'd1;
          ph_d = (j_q == LAST_VAR) ? 3'd5 : 3'd2;
        end
        3'd4: begin
          if (vs_rd.value == VAL_FREE) begin
            if (free_q != 2'd2) free_d = free_q + 2'd1;
            unit_d = var_q;
            upos_d = (lit == LIT_POS);
          end else if ((lit == LIT_POS && vs_rd.value == VAL_TRUE) ||
                       (lit == LIT_NEG && vs_rd.value == VAL_FALSE)) begin
            csat_d = 1'b1;
          end
          j_d = j_q + 3'd1;
          ph_d = (j_q == LAST_VAR) ? 3'd5 : 3'd2;
        end
        3'd5: begin
          ph_d = 3'd6;
          if (!csat_q && free_q == 2'd0) begin
            state_d = S_BACKTRACK;
            ph_d = 3'd0;
          end else if (!csat_q && free_q == 2'd1) begin
            i_vs_we = 1'b1;
            i_vs_addr = unit_q;
            i_vs_din = '{value: upos_q ? VAL_TRUE : VAL_FALSE,
                         implied: 1'b1, level: level_q};
            chg_d = 1'b1;
          end
        end
        default: begin
          ph_d = 3'd0;
          if (slot_q == LAST_CLS) begin
            slot_d = '0;
            if (last_bin) begin
              bin_d = '0;
              // A quiet sweep means propagation reached a fixpoint.
              if (chg_q) chg_d = 1'b0;
              else begin
                state_d = S_DECIDE;
                j_d = '0;
              end
            end else bin_d = bin_q + 1'b1;
          end else slot_d = slot_q + 3'd1;
        end
      endcase
      S_DECIDE: case (ph_q)
        3'd0: begin
          i_v_addr = slot_addr(bin_q, j_q);
          ph_d = 3'd1;
        end
        3'd1: if (v_rd != '0) begin
          i_vs_addr = v_rd[ADDR_W-1:0];
          var_d = v_rd[ADDR_W-1:0];
          ph_d = 3'd2;
        end else ph_d = 3'd3;
        3'd2: if (vs_rd.value == VAL_FREE) begin
          level_d = lvl_inc;
          i_vs_we = 1'b1;
          i_vs_addr = var_q;
          i_vs_din = '{value: VAL_FALSE, implied: 1'b0, level: lvl_inc};
          i_ls_we = 1'b1;
          i_ls_addr = lvl_inc[ADDR_W-1:0];
          i_ls_din = '{dcd_bin: bin_q, has_bkt: 1'b0};
          state_d = S_PROPAGATE;
          ph_d = '0;  bin_d = '0;  slot_d = '0;  chg_d = 1'b0;
        end else ph_d = 3'd3;
        default: begin
          ph_d = 3'd0;
          j_d = j_q + 3'd1;
          if (j_q == LAST_VAR) begin
            if (last_bin) begin
              state_d = S_FINISH;
              done_d = 1'b1;
              gsat_d = 1'b1;
            end else bin_d = bin_q + 1'b1;
          end
        end
      endcase
      S_BACKTRACK: case (ph_q)
        3'd0: if (level_q == '0) begin
          state_d = S_FINISH;
          done_d = 1'b1;
          gunsat_d = 1'b1;
        end else begin
          i_ls_addr = level_q[ADDR_W-1:0];
          ph_d = 3'd1;
        end
        3'd1: begin
          lsw_d = ls_rd;
          vid_d = 12'd1;
          ph_d = 3'd2;
        end
        3'd2: begin
          i_vs_addr = vid_q[ADDR_W-1:0];
          ph_d = 3'd3;
        end
        3'd3: begin
          // Untried decision flips to true; everything else at this level is freed.
          if (vs_rd.value != VAL_FREE && vs_rd.level == level_q) begin
            i_vs_we = 1'b1;
            i_vs_addr = vid_q[ADDR_W-1:0];
            if (!vs_rd.implied && !lsw_q.has_bkt)
              i_vs_din = '{value: VAL_TRUE, implied: 1'b0, level: level_q};
          end
          vid_d = vid_q + 12'd1;
          ph_d = (vid_q >= nv_q) ? 3'd4 : 3'd2;
        end
        default: begin
          ph_d = 3'd0;
          if (!lsw_q.has_bkt) begin
            i_ls_we = 1'b1;
            i_ls_addr = level_q[ADDR_W-1:0];
            i_ls_din = '{dcd_bin: lsw_q.dcd_bin, has_bkt: 1'b1};
            state_d = S_PROPAGATE;
            bin_d = '0;  slot_d = '0;  chg_d = 1'b0;
          end else level_d = level_q - 16'd1;
        end
      endcase
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;  ph_q <= '0;
      bin_q <= '0;  slot_q <= '0;  j_q <= '0;
      cw_q <= '0;  free_q <= '0;  csat_q <= 1'b0;
      upos_q <= 1'b0;  chg_q <= 1'b0;
      var_q <= '0;  unit_q <= '0;
      level_q <= '0;  vid_q <= '0;  lsw_q <= '0;
      nv_q <= '0;  nb_q <= '0;
      done_q <= 1'b0;  gsat_q <= 1'b0;  gunsat_q <= 1'b0;
    end else begin
      state_q <= state_d;  ph_q <= ph_d;
      bin_q <= bin_d;  slot_q <= slot_d;  j_q <= j_d;
      cw_q <= cw_d;  free_q <= free_d;  csat_q <= csat_d;
      upos_q <= upos_d;  chg_q <= chg_d;
      var_q <= var_d;  unit_q <= unit_d;
      level_q <= level_d;  vid_q <= vid_d;  lsw_q <= lsw_d;
      nv_q <= nv_d;  nb_q <= nb_d;
      done_q <= done_d;  gsat_q <= gsat_d;  gunsat_q <= gunsat_d;
    end
  end

  assign done_o         = done_q;
  assign global_sat_o   = gsat_q;
  assign global_unsat_o = gunsat_q;

endmodule

// File: tb/tb_sat_bin.sv
// Bench for sat_bin: directed and random CNF problems, results
// scored against a brute-force satisfiability model.
module tb_sat_bin;

  logic clk, rst, start, done, gsat, gunsat;
  logic bin_en, apply_ex;
  logic [11:0] nv_all;
  logic [15:0] nb_all;
  logic we_c, we_v, we_vs, we_ls;
  logic [15:0] din_c;
  logic [11:0] din_v;
  logic [18:0] din_vs;
  logic [10:0] din_ls;
  logic [8:0] addr_c, addr_v, addr_vs, addr_ls;

  int checks = 0;
  int errors = 0;
  bit sb[$];

  logic [15:0] clw [2][8];
  logic [11:0] vm [2][8];
  int nv, nb;

  sat_bin dut (
    .clk(clk), .rst(rst), .start_i(start), .done_o(done),
    .global_sat_o(gsat), .global_unsat_o(gunsat),
    .bin_info_en(bin_en), .nv_all_i(nv_all), .nb_all_i(nb_all),
    .apply_ex_i(apply_ex),
    .ram_we_c_ex_i(we_c), .ram_din_c_ex_i(din_c), .ram_addr_c_ex_i(addr_c),
    .ram_we_v_ex_i(we_v), .ram_din_v_ex_i(din_v), .ram_addr_v_ex_i(addr_v),
    .ram_we_vs_ex_i(we_vs), .ram_din_vs_ex_i(din_vs), .ram_addr_vs_ex_i(addr_vs),
    .ram_we_ls_ex_i(we_ls), .ram_din_ls_ex_i(din_ls), .ram_addr_ls_ex_i(addr_ls)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic bit ref_sat();
    for (int a = 0; a < (1 << nv); a++) begin
      bit ok;
      ok = 1;
      for (int b = 0; b < nb; b++)
        for (int c = 0; c < 8; c++)
          if (clw[b][c] != 0) begin
            bit hit;
            hit = 0;
            for (int j = 0; j < 8; j++) begin
              logic [1:0] code;
              int id;
              bit v;
              code = clw[b][c][2*j +: 2];
              id = int'(vm[b][j]);
              v = (id != 0) && (((a >> (id - 1)) & 1) == 1);
              if (id != 0 && ((code == 2'b01 && v) || (code == 2'b10 && !v)))
                hit = 1;
            end
            if (!hit) ok = 0;
          end
      if (ok) return 1;
    end
    return 0;
  endfunction

  task automatic check_model();
    int bad;
    bad = 0;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < 8; c++)
        if (clw[b][c] != 0) begin
          bit hit;
          hit = 0;
          for (int j = 0; j < 8; j++) begin
            logic [1:0] code, val;
            logic [8:0] idx;
            code = clw[b][c][2*j +: 2];
            idx = vm[b][j][8:0];
            val = dut.u_vs.mem[idx][18:17];
            if (vm[b][j] != 0 &&
                ((code == 2'b01 && val == 2'b10) ||
                 (code == 2'b10 && val == 2'b01)))
              hit = 1;
          end
          if (!hit) bad++;
        end
    chk("unsatisfied_clauses_in_vs", bad, 0);
  endtask

  // Scoreboard monitor: one expectation per rising done_o.
  initial begin
    bit seen, e;
    seen = 0;
    forever begin
      @(negedge clk);
      if (!done) seen = 0;
      else if (!seen) begin
        seen = 1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done_o=1 required no completion");
        end else begin
          e = sb.pop_front();
          chk("sat_unsat", {gsat, gunsat}, {e, !e});
          if (e) check_model();
        end
      end
    end
  end

  task automatic clear_prob();
    for (int b = 0; b < 2; b++)
      for (int s = 0; s < 8; s++) begin
        clw[b][s] = '0;
        vm[b][s] = '0;
      end
  endtask

  task automatic load();
    @(negedge clk);
    apply_ex = 1;
    for (int b = 0; b < 2; b++)
      for (int s = 0; s < 8; s++) begin
        we_c = 1; we_v = 1;
        addr_c = 9'(b * 8 + s + 1);
        addr_v = 9'(b * 8 + s + 1);
        din_c = clw[b][s];
        din_v = vm[b][s];
        @(negedge clk);
      end
    we_c = 0; we_v = 0;
    for (int i = 0; i < 8; i++) begin
      we_vs = 1; addr_vs = 9'(i); din_vs = '0;
      @(negedge clk);
    end
    we_vs = 0;
    apply_ex = 0;
  endtask

  task automatic kick();
    @(negedge clk);
    bin_en = 1; start = 1;
    nv_all = 12'(nv); nb_all = 16'(nb);
    @(negedge clk);
    bin_en = 0; start = 0;
  endtask

  task automatic wait_sb();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done_o after %0d cycles, required done_o=1", n);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input string name);
    sb.push_back(ref_sat());
    kick();
    chk({name, "_start_clears_done"}, done, 0);
    wait_sb();
  endtask

  task automatic gen_rand();
    clear_prob();
    nb = $urandom_range(1, 2);
    nv = $urandom_range(2, 4);
    for (int b = 0; b < nb; b++) begin
      int off;
      off = $urandom_range(0, nv - 1);
      for (int j = 0; j < nv; j++) vm[b][j] = 12'((j + off) % nv + 1);
      for (int c = 0; c < 6; c++)
        if ($urandom_range(0, 3) != 0)
          for (int j = 0; j < 8; j++) begin
            int r;
            r = $urandom_range(0, 7);
            clw[b][c][2*j +: 2] = (r < 2) ? 2'b01 : (r < 4) ? 2'b10 :
                                  (r == 7) ? 2'b11 : 2'b00;
          end
    end
  endtask

  initial begin
    rst = 0; start = 0; bin_en = 0; apply_ex = 0;
    nv_all = '0; nb_all = '0;
    we_c = 0; we_v = 0; we_vs = 0; we_ls = 0;
    din_c = '0; din_v = '0; din_vs = '0; din_ls = '0;
    addr_c = '0; addr_v = '0; addr_vs = '0; addr_ls = '0;
    repeat (3) @(negedge clk);
    chk("reset_done", done, 0);
    chk("reset_sat", gsat, 0);
    chk("reset_unsat", gunsat, 0);
    rst = 1;

    // (x1|x2),(~x1)
    clear_prob(); nb = 1; nv = 2;
    vm[0][0] = 1; vm[0][1] = 2;
    clw[0][0] = 16'h0005; clw[0][1] = 16'h0002;
    load();
    chk("rb_clause1", dut.u_c.mem[1], 16'h0005);
    chk("rb_clause2", dut.u_c.mem[2], 16'h0002);
    chk("rb_vmap2", dut.u_v.mem[2], 12'd2);
    @(negedge clk);
    apply_ex = 1; we_ls = 1; addr_ls = 9'd7; din_ls = 11'h2a5;
    @(negedge clk);
    we_ls = 0; apply_ex = 0;
    chk("rb_ls7", dut.u_ls.mem[7], 11'h2a5);
    run("t1");
    chk("t1_x1_value", dut.u_vs.mem[1][18:17], 2'b01);
    chk("t1_x2_value", dut.u_vs.mem[2][18:17], 2'b10);
    chk("t1_x2_implied", dut.u_vs.mem[2][16], 1'b1);
    repeat (10) @(negedge clk);
    chk("done_held", done, 1);
    chk("sat_held", gsat, 1);

    // (x1),(~x1)
    clear_prob(); nb = 1; nv = 1;
    vm[0][0] = 1;
    clw[0][0] = 16'h0001; clw[0][1] = 16'h0002;
    load();
    chk("done_held_over_load", done, 1);
    run("t2");
    chk("t2_sat_low", gsat, 0);

    // Two bins sharing x1..x3
    clear_prob(); nb = 2; nv = 3;
    for (int b = 0; b < 2; b++)
      for (int j = 0; j < 3; j++) vm[b][j] = 12'(j + 1);
    clw[0][0] = 16'h0005; clw[0][1] = 16'h0012;
    clw[1][0] = 16'h0020; clw[1][1] = 16'h0018;
    load();
    run("t3_unsat");
    clw[1][1] = '0;
    load();
    run("t3_sat");

    // Sparse clause slots with zero words between them
    clear_prob(); nb = 1; nv = 2;
    vm[0][0] = 1; vm[0][1] = 2;
    clw[0][2] = 16'h0005; clw[0][5] = 16'h0008;
    load();
    run("t4");

    // Reset during a run, then a clean rerun
    clear_prob(); nb = 2; nv = 3;
    for (int b = 0; b < 2; b++)
      for (int j = 0; j < 3; j++) vm[b][j] = 12'(j + 1);
    clw[0][0] = 16'h0005; clw[0][1] = 16'h0012; clw[1][0] = 16'h0020;
    load();
    kick();
    repeat (6) @(negedge clk);
    rst = 0;
    #1;
    chk("midrst_done", done, 0);
    chk("midrst_sat", gsat, 0);
    chk("midrst_unsat", gunsat, 0);
    @(negedge clk);
    rst = 1;
    load();
    run("t5_rerun");

    for (int k = 0; k < 10; k++) begin
      gen_rand();
      load();
      run("rand");
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
